// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, depth helper, Gray-code helpers, flag bundle.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 4;
  localparam int unsigned FIFO_GRAY_W     = 32;

  // Level flags decoded from the fill count
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Number of storage words for a given address width
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Binary to reflected Gray code
  function automatic logic [FIFO_GRAY_W-1:0] bin2gray(input logic [FIFO_GRAY_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code back to binary (prefix XOR from the MSB down)
  function automatic logic [FIFO_GRAY_W-1:0] gray2bin(input logic [FIFO_GRAY_W-1:0] gray);
    logic [FIFO_GRAY_W-1:0] bin;
    bin = '0;
    bin[FIFO_GRAY_W-1] = gray[FIFO_GRAY_W-1];
    for (int i = FIFO_GRAY_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, read port registered (FWFT=0)
// or combinational (FWFT=1).
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (FWFT) begin : g_fwft
    logic unused_fwft;
    assign unused_fwft = ^{re_i, rst_n};
    // Head word is always presented
    assign rdata_o = mem_q[raddr_i];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    // Registered read, holds when no read is accepted
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with fill count, almost flags, error pulses and optional FWFT.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = FIFO_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH  = 14,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter bit          FWFT          = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  // Parameter legality
  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("fifo_sync_param: ADDR_WIDTH must be at least 1");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
    $error("fifo_sync_param: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_sync_param: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  fifo_flags_t      flags_c;

  // Flags depend only on the registered count
  always_comb begin
    flags_c              = '0;
    flags_c.full         = (count_q == PTR_W'(DEPTH));
    flags_c.empty        = (count_q == '0);
    flags_c.almost_full  = (count_q >= PTR_W'(AFULL_THRESH));
    flags_c.almost_empty = (count_q <= PTR_W'(AEMPTY_THRESH));
  end

  assign wr_acc = wr_en & ~flags_c.full;
  assign rd_acc = rd_en & ~flags_c.empty;

  // Next-state for pointers, count and error pulses
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en & flags_c.full;
    underflow_d = rd_en & flags_c.empty;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wdata),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

  assign full         = flags_c.full;
  assign empty        = flags_c.empty;
  assign almost_full  = flags_c.almost_full;
  assign almost_empty = flags_c.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: registered-read instance plus an FWFT instance.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       wr_en, rd_en;
  logic [7:0] wdata, rdata;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en, f_rd_en;
  logic [7:0] f_wdata, f_rdata;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .rdata(rdata),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b1)
  ) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wdata(f_wdata), .rd_en(f_rd_en), .rdata(f_rdata),
    .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
    .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, " empty"}, 32'(empty), 32'd1);
    check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, " count"}, 32'(count), 32'd0);
    check({tag, " full"}, 32'(full), 32'd0);
    check({tag, " almost_full"}, 32'(almost_full), 32'd0);
    check({tag, " rdata"}, 32'(rdata), 32'd0);
    check({tag, " overflow"}, 32'(overflow), 32'd0);
    check({tag, " underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wdata = 8'h00;

    // Reset state, then idle after release
    #3;
    check_idle_reset("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check_idle_reset("idle");

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wdata = 8'(i);
      tick();
      check("fill count", 32'(count), 32'(i + 1));
      check("fill almost_empty", 32'(almost_empty), 32'((i + 1) <= 2));
      check("fill almost_full", 32'(almost_full), 32'((i + 1) >= 14));
      check("fill full", 32'(full), 32'((i + 1) == 16));
      check("fill empty", 32'(empty), 32'd0);
    end

    // 17th write rejected
    wdata = 8'hFF;
    tick();
    check("ovf pulse", 32'(overflow), 32'd1);
    check("ovf count", 32'(count), 32'd16);
    wr_en = 1'b0;
    tick();
    check("ovf clear", 32'(overflow), 32'd0);
    check("ovf count hold", 32'(count), 32'd16);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      check("drain rdata", 32'(rdata), 32'(i));
      check("drain count", 32'(count), 32'(15 - i));
    end
    check("drain empty", 32'(empty), 32'd1);
    tick();
    check("udf pulse", 32'(underflow), 32'd1);
    check("udf rdata hold", 32'(rdata), 32'h0F);
    check("udf count", 32'(count), 32'd0);
    rd_en = 1'b0;
    tick();
    check("udf clear", 32'(underflow), 32'd0);

    // Simultaneous read/write at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wdata = 8'(8'h20 + i);
      tick();
    end
    check("rw5 pre count", 32'(count), 32'd5);
    for (int j = 0; j < 20; j++) begin
      wr_en = 1'b1; rd_en = 1'b1; wdata = 8'(8'h25 + j);
      tick();
      check("rw5 rdata", 32'(rdata), 32'(8'h20 + j));
      check("rw5 count", 32'(count), 32'd5);
    end
    wr_en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      rd_en = 1'b1;
      tick();
      check("rw5 tail rdata", 32'(rdata), 32'(8'h34 + j));
    end
    rd_en = 1'b0;
    tick();
    check("rw5 end empty", 32'(empty), 32'd1);

    // Full boundary: only the read is accepted
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wdata = 8'(8'h40 + i);
      tick();
    end
    check("fb full", 32'(full), 32'd1);
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hEE;
    tick();
    check("fb count", 32'(count), 32'd15);
    check("fb overflow", 32'(overflow), 32'd1);
    check("fb rdata", 32'(rdata), 32'h40);
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    check("fb ovf clear", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      check("fb drain rdata", 32'(rdata), 32'(8'h40 + i));
    end
    rd_en = 1'b0;
    tick();
    check("fb end count", 32'(count), 32'd0);

    // Empty boundary: only the write is accepted
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h77;
    tick();
    check("eb count", 32'(count), 32'd1);
    check("eb underflow", 32'(underflow), 32'd1);
    check("eb empty", 32'(empty), 32'd0);
    check("eb rdata hold", 32'(rdata), 32'h4F);
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    check("eb rdata", 32'(rdata), 32'h77);
    check("eb count after", 32'(count), 32'd0);
    check("eb udf clear", 32'(underflow), 32'd0);
    rd_en = 1'b0;

    // Reset mid-stream at count 9
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wdata = 8'(8'h90 + i);
      tick();
    end
    wr_en = 1'b0;
    check("mid pre count", 32'(count), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_reset("midrst");
    #1;
    rst_n = 1'b1;
    wr_en = 1'b1; wdata = 8'hC3;
    tick();
    check("post rst count", 32'(count), 32'd1);
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    check("post rst rdata", 32'(rdata), 32'hC3);
    check("post rst empty", 32'(empty), 32'd1);
    rd_en = 1'b0;

    // FWFT instance: head word visible without a read
    f_wr_en = 1'b1; f_wdata = 8'hA5;
    tick();
    f_wr_en = 1'b0;
    check("fwft rdata", 32'(f_rdata), 32'hA5);
    check("fwft empty", 32'(f_empty), 32'd0);
    check("fwft count", 32'(f_count), 32'd1);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check("fwft pop empty", 32'(f_empty), 32'd1);
    check("fwft pop count", 32'(f_count), 32'd0);
    f_wr_en = 1'b1; f_wdata = 8'h11;
    tick();
    f_wdata = 8'h22;
    tick();
    f_wr_en = 1'b0;
    check("fwft head1", 32'(f_rdata), 32'h11);
    tick();
    check("fwft head1 hold", 32'(f_rdata), 32'h11);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check("fwft head2", 32'(f_rdata), 32'h22);
    check("fwft count2", 32'(f_count), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
